// File: rtl/spike_isi_logger.sv
// Spike train to inter-spike-interval event converter.
// Events queue in a small FWFT FIFO and drain over valid/ready.
module spike_isi_logger #(
  parameter int ISI_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          spike_in,
  output logic [ISI_WIDTH-1:0]          evt_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_WIDTH-1:0]         drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [ISI_WIDTH-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [ISI_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic                  spike_ev;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [ISI_WIDTH-1:0]  isi_val;

  assign spike_ev = ena & spike_in;
  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign pop      = evt_valid & evt_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push     = spike_ev & (~full | pop);
  assign drop     = spike_ev & full & ~pop;

  assign isi_val  = (&cnt_q) ? cnt_q
                             : cnt_q + ISI_WIDTH'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (ena) begin
      cnt_d = spike_in ? '0 : isi_val;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    drop_d  = drop_q;
    if (pop) begin
      head_d = head_q + AW'(1);
    end
    if (push) begin
      tail_d = tail_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (drop && !(&drop_q)) begin
      drop_d = drop_q + DROP_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[tail_q] <= isi_val;
    end
  end

  assign evt_valid  = (level_q != '0);
  assign evt_data   = evt_valid ? mem_q[head_q] : '0;
  assign fifo_level = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_spike_isi_logger.sv
// Self-checking bench for spike_isi_logger.
// Table vectors, directed corners, random vs queue model.
module tb_spike_isi_logger;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       spike_in;
  logic       evt_ready;
  logic [7:0] evt_data;
  logic       evt_valid;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;

  int n_cmp  = 0;
  int n_fail = 0;

  int q[$];
  int m_cnt  = 0;
  int m_drop = 0;

  typedef struct {
    logic e;
    logic s;
    logic r;
    logic v;
    int   d;
    int   l;
    int   dr;
  } vec_t;

  vec_t tbl[11];

  spike_isi_logger #(
    .ISI_WIDTH(8),
    .FIFO_DEPTH(4),
    .DROP_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .spike_in(spike_in),
    .evt_data(evt_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .fifo_level(fifo_level),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic check_model();
    chk("model_valid", int'(evt_valid),
        (q.size() != 0) ? 1 : 0);
    chk("model_data", int'(evt_data),
        (q.size() != 0) ? q[0] : 0);
    chk("model_level", int'(fifo_level), q.size());
    chk("model_drop", int'(drop_count), m_drop);
  endtask

  task automatic model_step(input logic r, e, s, rd);
    bit pop;
    int ev;
    if (r) begin
      q.delete();
      m_cnt  = 0;
      m_drop = 0;
      return;
    end
    pop = (q.size() != 0) && rd;
    ev  = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    if (pop) void'(q.pop_front());
    if (e && s) begin
      if (q.size() < 4) q.push_back(ev);
      else if (m_drop < 255) m_drop++;
      m_cnt = 0;
    end else if (e) begin
      m_cnt = ev;
    end
  endtask

  task automatic drive(input logic r, e, s, rd);
    rst       = r;
    ena       = e;
    spike_in  = s;
    evt_ready = rd;
    @(posedge clk);
    model_step(r, e, s, rd);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, rd);
  endtask

  task automatic spike(input logic rd);
    drive(1'b0, 1'b1, 1'b1, rd);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0;
    spike_in = 1'b0; evt_ready = 1'b0;

    // enabled cycles 1..11, spikes on 3, 4, 10
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 3, 1, 0};
    tbl[3]  = '{1, 1, 1, 1, 1, 1, 0};
    tbl[4]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[5]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 1, 6, 1, 0};
    tbl[10] = '{1, 0, 1, 0, 0, 0, 0};

    do_reset();
    chk("rst_valid", int'(evt_valid), 0);
    chk("rst_data", int'(evt_data), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_drop", int'(drop_count), 0);

    for (int i = 0; i < 11; i++) begin
      drive(1'b0, tbl[i].e, tbl[i].s, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i),
          int'(evt_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d_data", i),
          int'(evt_data), tbl[i].d);
      chk($sformatf("tbl%0d_level", i),
          int'(fifo_level), tbl[i].l);
      chk($sformatf("tbl%0d_drop", i),
          int'(drop_count), tbl[i].dr);
    end

    // ISI saturation
    do_reset();
    idle(300, 1'b0);
    spike(1'b0);
    chk("sat_data", int'(evt_data), 255);
    idle(1, 1'b0);
    spike(1'b0);
    chk("sat_level", int'(fifo_level), 2);
    idle(1, 1'b1);
    chk("sat_next", int'(evt_data), 2);
    idle(1, 1'b1);
    chk("sat_empty", int'(evt_valid), 0);

    // overflow with ISIs 1..6
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      idle(i - 1, 1'b0);
      spike(1'b0);
    end
    chk("ovf_level", int'(fifo_level), 4);
    chk("ovf_drop", int'(drop_count), 2);
    chk("ovf_head", int'(evt_data), 1);
    for (int i = 2; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("ovf_drain%0d", i),
          int'(evt_data), i);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf_empty", int'(evt_valid), 0);

    // push and pop together while full
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      idle(i - 1, 1'b0);
      spike(1'b0);
    end
    idle(2, 1'b0);
    spike(1'b1);
    chk("fpp_level", int'(fifo_level), 4);
    chk("fpp_drop", int'(drop_count), 0);
    chk("fpp_head", int'(evt_data), 2);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fpp_tail", int'(evt_data), 3);

    // ena low freezes cnt, draining continues
    do_reset();
    idle(2, 1'b0);
    spike(1'b0);
    idle(2, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 1'b1);
    chk("ena_level", int'(fifo_level), 0);
    spike(1'b0);
    chk("ena_isi", int'(evt_data), 3);

    // reset mid-activity
    do_reset();
    for (int i = 0; i < 5; i++) spike(1'b0);
    idle(1, 1'b1);
    idle(6, 1'b0);
    chk("prer_level", int'(fifo_level), 3);
    chk("prer_drop", int'(drop_count), 1);
    do_reset();
    chk("mrst_valid", int'(evt_valid), 0);
    chk("mrst_level", int'(fifo_level), 0);
    chk("mrst_drop", int'(drop_count), 0);
    idle(1, 1'b0);
    spike(1'b0);
    chk("mrst_isi", int'(evt_data), 2);

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 264; i++) spike(1'b0);
    chk("dsat_drop", int'(drop_count), 255);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_isi_logger.md
Name: spike_isi_logger

Overview:
- Sits directly downstream of the LIF neuron and consumes its per-cycle spike output.
- Converts the spike train into inter-spike-interval (ISI) events: the number of enabled cycles between consecutive spikes, saturated to 8 bits.
- Buffers events in a small first-word-fall-through FIFO.
- Presents events to a byte-wide valid/ready consumer (readout logic driving uio_out); a saturating counter records events dropped on overflow.

Parameters:
- ISI_WIDTH, 8, width of ISI counter and event data; saturates at 2^ISI_WIDTH-1.
- FIFO_DEPTH, 4, event buffer entries; must be a power of 2, at least 2.
- DROP_WIDTH, 8, width of saturating dropped-event counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  design enable; gates ISI counting and spike capture only.
- spike_in  input  1  neuron spike; each enabled cycle with spike_in=1 is one spike.
- evt_data  output  ISI_WIDTH  ISI value at FIFO head.
- evt_valid  output  1  FIFO non-empty.
- evt_ready  input  1  consumer accepts head when evt_valid=1.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
- drop_count  output  DROP_WIDTH  saturating count of spikes lost to a full FIFO.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at posedge):
  - ISI counter = 0; FIFO emptied (pointers 0).
  - evt_valid = 0, evt_data = 0, fifo_level = 0, drop_count = 0.
  - Reset overrides all other activity, including mid-transfer; any entries in flight are discarded.
- ISI counter (cnt), updated only on cycles with ena=1:
  - spike_in=0: cnt <= sat(cnt+1).
  - spike_in=1: event value E = sat(cnt+1); cnt <= 0.
  - sat() clamps at 2^ISI_WIDTH-1.
  - Spikes on two consecutive enabled cycles give E=1. The first spike on the k-th enabled cycle after reset (k counted from 1) gives E=k.
  - ena=0: cnt holds; spike_in is ignored (no event, no drop).
- Push: occurs when ena=1 and spike_in=1.
  - If FIFO not full, or full with a pop in the same cycle, E is written at the tail.
  - If full with no pop, E is discarded and drop_count <= sat(drop_count+1).
  - cnt resets to 0 in both cases: the spike is consumed either way.
- Pop: occurs when evt_valid=1 and evt_ready=1; head advances at posedge.
  - evt_ready with evt_valid=0 is ignored.
- FIFO output:
  - Registered storage, first-word-fall-through.
  - evt_valid = (level != 0); evt_data = storage[head], combinational from registered state.
  - evt_data = 0 when empty.
- Latency and ordering:
  - An event pushed into an empty FIFO at edge N is visible (evt_valid=1) after edge N; there is no same-cycle bypass.
  - Order is strictly FIFO.
- Simultaneous push and pop:
  - Level unchanged; both accepted at any level, including full and empty-becoming-nonempty.
  - Push on empty with no valid data cannot pop.
- Handshake stability: while evt_valid=1 and evt_ready=0, evt_data and evt_valid hold until a pop.
- Independence from ena: ena=0 does not stall draining; pops continue.
- Wrap-around: pointers wrap modulo FIFO_DEPTH; level tracks fullness unambiguously.
- Saturation: drop_count sticks at 2^DROP_WIDTH-1 until reset; the ISI counter sticks at max until a spike.

Test Plan:
- Reset, then ena=1, spike_in=1 on enabled cycles 3, 4, 10, evt_ready=1 -> events 3, 1, 6 in order; each evt_valid high exactly one cycle after its push edge; drop_count=0.
- ena=1, no spike for 300 cycles, then a spike -> event 255 (saturated); the next spike 2 cycles later -> event 2.
- evt_ready=0, spikes with ISIs 1, 2, 3, 4, 5, 6 -> fifo_level reaches 4; drop_count=2; evt_data holds 1. Raise evt_ready -> 1, 2, 3, 4 drained, then evt_valid=0.
- FIFO full (4 entries), evt_ready=1 on the same cycle as a spike -> push accepted, level stays 4, drop_count unchanged, head advances.
- ena toggled low for 5 cycles between spikes with spike_in held high while ena=0 -> no events pushed, cnt frozen; pending events still drain while ena=0.
- Assert rst with 3 queued events and cnt=7 -> next cycle evt_valid=0, fifo_level=0, drop_count=0; first post-reset spike on enabled cycle 2 -> event 2.
